vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: owns the horizontal and vertical pixel counters and produces the sync, blanking, pixel-position and strobe signals for the VGA controller.

- Generalises the fixed 640x480 sync decode into one block with configurable timing, sync polarity and pixel-clock division.
- Adds pause control and line/frame strobes for downstream pixel and frame-buffer logic.
- Sits between the system clock and the pixel/colour generator.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIX_DIV, 4, clk cycles per pixel; must be >= 1
- CNT_W, 16, width of the position counters

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  run/pause; low freezes all state
- hsync  out  1  horizontal sync at HSYNC_POL during sync window
- vsync  out  1  vertical sync at VSYNC_POL during sync window
- video  out  1  high when position is inside the visible area
- x_loc  out  CNT_W  current horizontal count
- y_loc  out  CNT_W  current vertical count
- pix_tick  out  1  one-clk pulse; counters advance at the end of this cycle
- line_start  out  1  one-clk pulse at first pixel of each line
- frame_start  out  1  one-clk pulse at first pixel of each frame

## Operation
- Totals: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK and V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK.
- H_TOTAL-1 and V_TOTAL-1 must fit in CNT_W bits. All compares are unsigned at CNT_W.
- Prescaler div_cnt counts 0..PIX_DIV-1 while enable = 1 and wraps to 0.
- pix_tick = enable && (div_cnt == PIX_DIV-1). When PIX_DIV = 1, pix_tick equals enable.
- On pix_tick, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount at V_TOTAL-1 wraps to 0 on the same tick that hcount wraps.
- x_loc = hcount and y_loc = vcount (registered).
- Visible area: video = (hcount < H_DISPLAY) && (vcount < V_DISPLAY).
- hsync is at its active level for hcount in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC); it is ~HSYNC_POL elsewhere.
- vsync uses the same window rule on vcount with the V parameters and VSYNC_POL.
- hsync, vsync and video are registered, computed from next-state counter values. In every clk they describe the same (x_loc, y_loc) pair, with zero skew.
- line_start = pix_tick && hcount == 0.
- frame_start = line_start && vcount == 0.
- When enable is low: div_cnt, the counters and all registered outputs hold; the strobes are 0.

## Timing
- Reset, sampled on clk, forces div_cnt = 0, hcount = 0 and vcount = 0.
- Outputs during reset: x_loc = 0, y_loc = 0, video = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, all strobes 0.
- First clk after reset deasserts: video = 1 (position 0,0). With enable = 1, pix_tick first fires PIX_DIV-1 clks later.
- Reset asserted mid-frame takes priority over enable and tick. State returns to the reset values at the next edge.
- Pixel period = PIX_DIV clk. Line = H_TOTAL*PIX_DIV clk. Frame = H_TOTAL*V_TOTAL*PIX_DIV clk.
- Every strobe is exactly one clk wide and never repeats within one pixel period.
- An enable drop during the pix_tick cycle suppresses that advance; no tick is lost or doubled afterwards.

## Test plan
- Defaults, reset then enable = 1:
  - x_loc steps every 4 clk.
  - video falls when x_loc = 640.
  - hsync is low exactly for x_loc 656..751 (384 clk) and high at 752.
- Line wrap: x_loc 799 -> 0 and y_loc +1 on the same edge; line_start pulses once every 3200 clk.
- Frame:
  - vsync is low exactly for y_loc 490..491 (6400 clk).
  - y_loc wraps 524 -> 0.
  - frame_start pulses once every 1,680,000 clk, coincident with line_start.
- Polarity: HSYNC_POL = 1 and VSYNC_POL = 1.
  - Both syncs idle low, including during reset.
  - Both go high only inside their windows (x 656..751, y 490..491).
- Small config: PIX_DIV = 1, H = 8/1/2/1, V = 4/1/1/1.
  - pix_tick equals enable.
  - Totals are 12 x 7; hsync is active for x 9..10; frame = 84 clk.
- Pause/reset:
  - enable low for 10 clk at x = 100: all outputs frozen, no strobes; counting resumes from the held div_cnt.
  - reset at y = 300 forces x = y = 0, video = 0 and syncs inactive on the next edge.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle
// from the timing generator to pixel logic
interface vga_timing_gen_if #(
  parameter int CNT_W = 16
);
  logic             hsync;
  logic             vsync;
  logic             video;
  logic [CNT_W-1:0] x_loc;
  logic [CNT_W-1:0] y_loc;
  logic             pix_tick;
  logic             line_start;
  logic             frame_start;

  modport master (
    output hsync, vsync, video,
    output x_loc, y_loc,
    output pix_tick, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, video,
    input x_loc, y_loc,
    input pix_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster
// counters, sync/blank decode and strobes
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_DIV   = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W =
    (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_MAX =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS =
    CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS =
    CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             tick;
  logic             h_act;
  logic             v_act;
  logic             vis_nxt;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_q;

  // Reset gates the strobes so they stay low
  // even when the prescaler matches.
  assign tick = enable && !reset &&
                (div_cnt == DIV_MAX);

  // Next-state prescaler and raster counters.
  always_comb begin
    div_nxt = div_cnt;
    h_nxt   = hcount;
    v_nxt   = vcount;
    if (enable) begin
      if (div_cnt == DIV_MAX)
        div_nxt = '0;
      else
        div_nxt = div_cnt + 1'b1;
    end
    if (tick) begin
      if (hcount == H_MAX) begin
        h_nxt = '0;
        if (vcount == V_MAX)
          v_nxt = '0;
        else
          v_nxt = vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
  end

  // Decode from next-state counters so the
  // registered flags line up with x/y.
  always_comb begin
    h_act   = (h_nxt >= HS_BEG) &&
              (h_nxt <  HS_END);
    v_act   = (v_nxt >= VS_BEG) &&
              (v_nxt <  VS_END);
    vis_nxt = (h_nxt < H_VIS) &&
              (v_nxt < V_VIS);
  end

  // Counter and prescaler state.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hcount  <= '0;
      vcount  <= '0;
    end else begin
      div_cnt <= div_nxt;
      hcount  <= h_nxt;
      vcount  <= v_nxt;
    end
  end

  // Registered sync/blank; a held position
  // re-decodes to the same values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      video_q <= 1'b0;
    end else begin
      hsync_q <= h_act ? HSYNC_POL
                       : ~HSYNC_POL;
      vsync_q <= v_act ? VSYNC_POL
                       : ~VSYNC_POL;
      video_q <= vis_nxt;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video       = video_q;
  assign vga.x_loc       = hcount;
  assign vga.y_loc       = vcount;
  assign vga.pix_tick    = tick;
  assign vga.line_start  = tick &&
                           (hcount == '0);
  assign vga.frame_start = tick &&
                           (hcount == '0) &&
                           (vcount == '0);

endmodule
